// File: rtl/pc_pkg.sv
// Shared defaults and next-pc source selection for the program counter unit.
package pc_pkg;

    localparam int          DEF_PC_W         = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_JR,
        SEL_RET,
        SEL_TRAP
    } pc_sel_e;

endpackage

// File: rtl/pc_ras_unit_ras_stack.sv
// Circular return-address stack: a push while full silently replaces the
// oldest entry, so the newest RAS_DEPTH return addresses are always kept.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     entries [DEPTH];
    logic [PTR_W-1:0] top_ptr_reg, top_ptr_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count_reg, count_next;
    logic             do_push, do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push;
    assign do_pop  = pop && !push && !empty;
    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign wr_ptr  = top_ptr_reg + PTR_W'(1);
    assign top     = entries[top_ptr_reg];
    assign count   = count_reg;

    always_comb begin
        top_ptr_next = top_ptr_reg;
        count_next   = count_reg;
        if (do_push) begin
            top_ptr_next = wr_ptr;
            if (!full) begin
                count_next = count_reg + (PTR_W+1)'(1);
            end
        end else if (do_pop) begin
            top_ptr_next = top_ptr_reg - PTR_W'(1);
            count_next   = count_reg - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr_reg <= '0;
            count_reg   <= '0;
        end else begin
            top_ptr_reg <= top_ptr_next;
            count_reg   <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr == PTR_W'(gi))) begin
                    entries[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pc_ras_unit.sv
// Next-pc generation with stall hold, trap entry and a call/return stack.
// Only the highest-priority request of a cycle acts; the rest are dropped.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int              PC_W         = DEF_PC_W,
    parameter int              JIDX_W       = 26,
    parameter int              IMM_W        = 16,
    parameter int              RAS_DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR),
    parameter logic [PC_W-1:0] TRAP_VECTOR  = PC_W'(DEF_TRAP_VECTOR)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         trap,
    input  logic                         branch,
    input  logic                         zero,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         jr,
    input  logic [JIDX_W-1:0]            jidx,
    input  logic [IMM_W-1:0]             imm,
    input  logic [PC_W-1:0]              jr_target,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus,
    output logic                         redirect,
    output logic [$clog2(RAS_DEPTH):0]   ras_depth,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] br_target, jmp_target, ras_top;
    logic            hold, push, pop, ras_full, ras_empty;
    logic            redirect_reg, redirect_next;
    logic            overflow_reg, overflow_next;
    logic            underflow_reg, underflow_next;
    pc_sel_e         sel;

    assign pc_plus    = pc_reg + PC_W'(4);
    assign br_target  = pc_plus + {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    assign jmp_target = {pc_plus[PC_W-1:JIDX_W+2], jidx, 2'b00};

    // Priority encoder; stall is not a pc source, so it is carried as hold.
    always_comb begin
        sel            = SEL_SEQ;
        hold           = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (stall) begin
            hold = 1'b1;
        end else if (ret) begin
            sel            = SEL_RET;
            pop            = !ras_empty;
            underflow_next = ras_empty;
        end else if (jr) begin
            sel = SEL_JR;
        end else if (call || jump) begin
            sel           = SEL_JMP;
            push          = call;
            overflow_next = call && ras_full;
        end else if (branch && zero) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next = pc_plus;
        case (sel)
            SEL_TRAP: pc_next = TRAP_VECTOR;
            SEL_RET:  pc_next = ras_empty ? jr_target : ras_top;
            SEL_JR:   pc_next = jr_target;
            SEL_JMP:  pc_next = jmp_target;
            SEL_BR:   pc_next = br_target;
            default:  pc_next = pc_plus;
        endcase
        if (hold) begin
            pc_next = pc_reg;
        end
        redirect_next = !hold && (sel != SEL_SEQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg        <= RESET_VECTOR;
            redirect_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            redirect_reg  <= redirect_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .count     (ras_depth)
    );

    assign pc            = pc_reg;
    assign redirect      = redirect_reg;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench: a driver feeds directed and random control words and
// queues the reference model's result; a monitor checks each cycle's outputs.
module tb_pc_ras_unit;

    typedef struct {
        logic        rst, stl, trp, br, z, jmp, cl, rt, j_r;
        logic [25:0] jidx;
        logic [15:0] imm;
        logic [31:0] jt;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic        redir;
        int          depth;
        logic        ovf, unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, trap, branch, zero, jump, call, ret, jr;
    logic [25:0] jidx;
    logic [15:0] imm;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_plus;
    logic        redirect, ras_overflow, ras_underflow;
    logic [3:0]  ras_depth;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    exp_t sb[$];

    // Reference model state: pc and the stack as a bounded queue (newest at back).
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_ras_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .trap          (trap),
        .branch        (branch),
        .zero          (zero),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jr            (jr),
        .jidx          (jidx),
        .imm           (imm),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .redirect      (redirect),
        .ras_depth     (ras_depth),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.stl = 0; s.trp = 0; s.br = 0; s.z = 0;
        s.jmp = 0; s.cl = 0; s.rt = 0; s.j_r = 0;
        s.jidx = '0; s.imm = '0; s.jt = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        s.rst  = ($urandom_range(63) == 0);
        s.stl  = ($urandom_range(5) == 0);
        s.trp  = ($urandom_range(15) == 0);
        s.br   = ($urandom_range(3) == 0);
        s.z    = $urandom_range(1) == 1;
        s.jmp  = ($urandom_range(6) == 0);
        s.cl   = ($urandom_range(3) == 0);
        s.rt   = ($urandom_range(4) == 0);
        s.j_r  = ($urandom_range(7) == 0);
        s.jidx = 26'($urandom);
        s.imm  = 16'($urandom);
        s.jt   = $urandom;
        return s;
    endfunction

    task automatic model(input stim_t s, output exp_t e);
        logic [31:0] nxt = m_pc + 32'd4;
        e.redir = 1'b1; e.ovf = 1'b0; e.unf = 1'b0;
        if (s.rst) begin
            m_pc = 32'h0; m_ras.delete(); e.redir = 1'b0;
        end else if (s.trp) begin
            m_pc = 32'h80;
        end else if (s.stl) begin
            e.redir = 1'b0;
        end else if (s.rt) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = s.jt; e.unf = 1'b1; end
        end else if (s.j_r) begin
            m_pc = s.jt;
        end else if (s.cl || s.jmp) begin
            m_pc = (nxt & 32'hF000_0000) | (32'(s.jidx) << 2);
            if (s.cl) begin
                m_ras.push_back(nxt);
                if (m_ras.size() > 8) begin
                    void'(m_ras.pop_front());
                    e.ovf = 1'b1;
                end
            end
        end else if (s.br && s.z) begin
            m_pc = nxt + 32'(int'($signed(s.imm)) * 4);
        end else begin
            m_pc = nxt; e.redir = 1'b0;
        end
        e.pc    = m_pc;
        e.depth = m_ras.size();
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst; stall = s.stl; trap = s.trp; branch = s.br; zero = s.z;
        jump = s.jmp; call = s.cl; ret = s.rt; jr = s.j_r;
        jidx = s.jidx; imm = s.imm; jr_target = s.jt;
        model(s, e);
        sb.push_back(e);
    endtask

    task automatic jr_to(input logic [31:0] a);
        stim_t s = idle();
        s.j_r = 1; s.jt = a;
        drive(s);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s txn %0d: got %h, expected %h", name, n_txn, act, req);
        end
    endtask

    // Monitor: every cycle after an edge that consumed a driven word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                check("pc", pc, e.pc);
                check("pc_plus", pc_plus, e.pc + 32'd4);
                check("redirect", 32'(redirect), 32'(e.redir));
                check("ras_depth", 32'(ras_depth), 32'(e.depth));
                check("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
                check("ras_underflow", 32'(ras_underflow), 32'(e.unf));
                $display("txn %0d pc=%h redir=%b depth=%0d ovf=%b unf=%b",
                         n_txn, pc, redirect, ras_depth, ras_overflow, ras_underflow);
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cyc;
        m_pc = 32'h0;
        // T1: reset, idle count-up, stall hold
        s = idle(); s.rst = 1; drive(s);
        repeat (3) drive(idle());
        s = idle(); s.stl = 1; s.jmp = 1; drive(s); drive(s);
        // T2: taken and not-taken branch
        jr_to(32'h100);
        s = idle(); s.br = 1; s.z = 1; s.imm = 16'hFFFE; drive(s);
        jr_to(32'h100);
        s.z = 0; drive(s);
        // T3: call then ret
        jr_to(32'h1000);
        s = idle(); s.cl = 1; s.jidx = 26'h40; drive(s);
        s = idle(); s.rt = 1; drive(s);
        // T4: overflow, LIFO unwinding, underflow fallback
        for (int i = 0; i < 9; i++) begin
            s = idle(); s.cl = 1; s.jidx = 26'(16 * i + 3); drive(s);
        end
        for (int i = 0; i < 9; i++) begin
            s = idle(); s.rt = 1; s.jt = 32'hCAFE_0000 + 32'(i); drive(s);
        end
        // T5: trap beats stall and ret; reset beats stall
        s = idle(); s.cl = 1; s.jidx = 26'h123; drive(s);
        s = idle(); s.trp = 1; s.stl = 1; s.rt = 1; drive(s);
        s = idle(); s.rst = 1; s.stl = 1; drive(s);
        // T6: wraparound cases
        jr_to(32'hFFFF_FFFC);
        drive(idle());
        jr_to(32'hF000_0000);
        s = idle(); s.jmp = 1; s.jidx = 26'h3FF_FFFF; drive(s);
        // Random traffic
        for (int i = 0; i < 300; i++) drive(rand_stim());
        @(negedge clk);
        reset = 0; stall = 0; trap = 0; branch = 0; zero = 0;
        jump = 0; call = 0; ret = 0; jr = 0;
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
